// File: rtl/spi_master_cs.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : spi_master_cs
// Purpose  : SPI mode-0 master (CPOL=0, CPHA=0) that sends and receives up
//            to MAX_BYTES_PER_CS bytes while chip-select stays asserted.
//            o_SPI_Clk runs at w_SPI_Clk / (2*CLKS_PER_HALF_BIT).
// Ports    : w_SPI_Clk, i_Rst_L (async, active-low)
//            i_TX_Count/i_TX_Byte/i_TX_DV/o_TX_Ready : byte request side
//            o_RX_Count/o_RX_DV/o_RX_Byte            : received byte side
//            o_SPI_Clk/o_SPI_MOSI/o_SPI_CS_n/i_SPI_MISO : SPI bus
// Options  : SPI_MASTER_LOOPBACK_EN - receive shifter samples o_SPI_MOSI
//            instead of i_SPI_MISO.
// Revision : 1.0 - initial release
// ============================================================================
module spi_master_cs #(
  parameter int CLKS_PER_HALF_BIT = 2,
  parameter int MAX_BYTES_PER_CS  = 2,
  parameter int CS_INACTIVE_CLKS  = 1,
  localparam int CW = $clog2(MAX_BYTES_PER_CS + 1)
) (
  input  logic          w_SPI_Clk,
  input  logic          i_Rst_L,
  input  logic [CW-1:0] i_TX_Count,
  input  logic [7:0]    i_TX_Byte,
  input  logic          i_TX_DV,
  output logic          o_TX_Ready,
  output logic [CW-1:0] o_RX_Count,
  output logic          o_RX_DV,
  output logic [7:0]    o_RX_Byte,
  output logic          o_SPI_Clk,
  input  logic          i_SPI_MISO,
  output logic          o_SPI_MOSI,
  output logic          o_SPI_CS_n
);

  localparam int HW = $clog2(CLKS_PER_HALF_BIT);
  localparam int GW = (CS_INACTIVE_CLKS > 1) ? $clog2(CS_INACTIVE_CLKS) : 1;
  localparam logic [HW-1:0] C_HALF_LAST = HW'(CLKS_PER_HALF_BIT - 1);
  localparam logic [GW-1:0] C_GAP_LAST  = GW'(CS_INACTIVE_CLKS - 1);
  localparam logic [CW-1:0] C_MAX_BYTES = CW'(MAX_BYTES_PER_CS);
  localparam logic [4:0]    C_ALL_EDGES = 5'd16;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_CS_ASSERT = 3'd1,
    ST_SHIFT     = 3'd2,
    ST_WAIT_NEXT = 3'd3,
    ST_CS_GAP    = 3'd4
  } state_t;

  state_t        r_state;
  logic [HW-1:0] r_half_cnt;
  logic [4:0]    r_edge_cnt;    // SPI clock edges produced for this byte
  logic [7:0]    r_tx_shift;    // bit 7 is the bit currently on MOSI
  logic [7:0]    r_rx_shift;
  logic [CW-1:0] r_bytes_left;  // includes the byte in flight
  logic [GW-1:0] r_gap_cnt;
  logic          w_rx_sample;
  logic [CW-1:0] w_count_clamped;

`ifdef SPI_MASTER_LOOPBACK_EN
  logic w_unused_miso;
  assign w_unused_miso = i_SPI_MISO;
  assign w_rx_sample   = o_SPI_MOSI;
`else
  assign w_rx_sample   = i_SPI_MISO;
`endif

  // A zero count still moves one byte; oversize counts saturate.
  always_comb begin
    w_count_clamped = i_TX_Count;
    if (i_TX_Count == '0) begin
      w_count_clamped = CW'(1);
    end else if (i_TX_Count > C_MAX_BYTES) begin
      w_count_clamped = C_MAX_BYTES;
    end
  end

  always_ff @(posedge w_SPI_Clk or negedge i_Rst_L) begin
    if (!i_Rst_L) begin
      r_state      <= ST_IDLE;
      r_half_cnt   <= '0;
      r_edge_cnt   <= '0;
      r_tx_shift   <= '0;
      r_rx_shift   <= '0;
      r_bytes_left <= '0;
      r_gap_cnt    <= '0;
      o_TX_Ready   <= 1'b0;
      o_RX_Count   <= '0;
      o_RX_DV      <= 1'b0;
      o_RX_Byte    <= 8'h00;
      o_SPI_Clk    <= 1'b0;
      o_SPI_MOSI   <= 1'b0;
      o_SPI_CS_n   <= 1'b1;
    end else begin
      o_RX_DV <= 1'b0;
      if (o_RX_DV) begin
        o_RX_Count <= o_RX_Count + CW'(1);
      end

      case (r_state)
        ST_IDLE: begin
          o_SPI_CS_n <= 1'b1;
          o_SPI_Clk  <= 1'b0;
          if (o_TX_Ready && i_TX_DV) begin
            r_tx_shift   <= i_TX_Byte;
            o_SPI_MOSI   <= i_TX_Byte[7];
            r_bytes_left <= w_count_clamped;
            o_RX_Count   <= '0;
            o_TX_Ready   <= 1'b0;
            o_SPI_CS_n   <= 1'b0;
            r_half_cnt   <= '0;
            r_edge_cnt   <= '0;
            r_state      <= ST_CS_ASSERT;
          end else begin
            // Also the first clock after reset release raises ready.
            o_TX_Ready <= 1'b1;
          end
        end

        ST_CS_ASSERT: begin
          if (r_half_cnt == C_HALF_LAST) begin
            r_half_cnt <= '0;
            r_state    <= ST_SHIFT;
          end else begin
            r_half_cnt <= r_half_cnt + HW'(1);
          end
        end

        ST_SHIFT: begin
          // First cycle after the 8th falling edge: present the byte.
          if (r_edge_cnt == C_ALL_EDGES && r_half_cnt == '0) begin
            o_RX_DV   <= 1'b1;
            o_RX_Byte <= r_rx_shift;
          end
          if (r_half_cnt == C_HALF_LAST) begin
            r_half_cnt <= '0;
            if (r_edge_cnt != C_ALL_EDGES) begin
              o_SPI_Clk  <= ~o_SPI_Clk;
              r_edge_cnt <= r_edge_cnt + 5'd1;
              if (!r_edge_cnt[0]) begin
                // Even edge index = rising edge of o_SPI_Clk.
                r_rx_shift <= {r_rx_shift[6:0], w_rx_sample};
              end else if (r_edge_cnt != 5'd15) begin
                // Falling edges 1..7 advance MOSI; the 8th leaves bit 0.
                o_SPI_MOSI <= r_tx_shift[6];
                r_tx_shift <= {r_tx_shift[6:0], 1'b0};
              end
            end else if (r_bytes_left > CW'(1)) begin
              // Trailing half period done; keep CS low for the next byte.
              r_bytes_left <= r_bytes_left - CW'(1);
              o_TX_Ready   <= 1'b1;
              r_state      <= ST_WAIT_NEXT;
            end else begin
              o_SPI_CS_n <= 1'b1;
              r_gap_cnt  <= '0;
              r_state    <= ST_CS_GAP;
            end
          end else begin
            r_half_cnt <= r_half_cnt + HW'(1);
          end
        end

        ST_WAIT_NEXT: begin
          o_SPI_CS_n <= 1'b0;
          o_SPI_Clk  <= 1'b0;
          if (o_TX_Ready && i_TX_DV) begin
            r_tx_shift <= i_TX_Byte;
            o_SPI_MOSI <= i_TX_Byte[7];
            o_TX_Ready <= 1'b0;
            r_half_cnt <= '0;
            r_edge_cnt <= '0;
            r_state    <= ST_CS_ASSERT;
          end else begin
            o_TX_Ready <= 1'b1;
          end
        end

        ST_CS_GAP: begin
          o_SPI_CS_n <= 1'b1;
          if (r_gap_cnt == C_GAP_LAST) begin
            o_TX_Ready <= 1'b1;
            r_state    <= ST_IDLE;
          end else begin
            o_TX_Ready <= 1'b0;
            r_gap_cnt  <= r_gap_cnt + GW'(1);
          end
        end

        default: begin
          o_TX_Ready <= 1'b0;
          o_SPI_CS_n <= 1'b1;
          o_SPI_Clk  <= 1'b0;
          r_state    <= ST_IDLE;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_spi_master_cs.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tb_spi_master_cs
// Purpose  : Self-checking bench for spi_master_cs (H=2, MAX=2, gap=1).
//            Table of directed transactions, hand-written corner sequences
//            (request during SHIFT, reset mid-byte) and random transactions
//            checked against a byte-level reference model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_spi_master_cs;

  localparam int H    = 2;
  localparam int MAXB = 2;
  localparam int GAP  = 1;
  localparam int CW   = $clog2(MAXB + 1);

  logic          clk   = 1'b0;
  logic          rst_l = 1'b0;
  logic [CW-1:0] tx_count = '0;
  logic [7:0]    tx_byte  = 8'h00;
  logic          tx_dv    = 1'b0;
  logic          tx_ready;
  logic [CW-1:0] rx_count;
  logic          rx_dv;
  logic [7:0]    rx_byte;
  logic          sclk, mosi, cs_n;
  logic          miso = 1'b0;

  always #5 clk = ~clk;

  spi_master_cs #(
    .CLKS_PER_HALF_BIT (H),
    .MAX_BYTES_PER_CS  (MAXB),
    .CS_INACTIVE_CLKS  (GAP)
  ) dut (
    .w_SPI_Clk  (clk),
    .i_Rst_L    (rst_l),
    .i_TX_Count (tx_count),
    .i_TX_Byte  (tx_byte),
    .i_TX_DV    (tx_dv),
    .o_TX_Ready (tx_ready),
    .o_RX_Count (rx_count),
    .o_RX_DV    (rx_dv),
    .o_RX_Byte  (rx_byte),
    .o_SPI_Clk  (sclk),
    .i_SPI_MISO (miso),
    .o_SPI_MOSI (mosi),
    .o_SPI_CS_n (cs_n)
  );

  int n_cmp = 0;
  int n_bad = 0;

  // ---------------- slave model (mode 0) ----------------
  logic [7:0] sl_arr [2];
  int         s_idx;
  int         s_falls;

  always begin
    @(negedge cs_n);
    s_idx   = 0;
    s_falls = 0;
    miso    = sl_arr[0][7];
    while (cs_n === 1'b0) begin
      @(negedge sclk or posedge cs_n);
      if (cs_n !== 1'b0) break;
      s_falls++;
      if (s_falls == 8) begin
        s_falls = 0;
        if (s_idx < 1) s_idx++;
        miso = sl_arr[s_idx][7];
      end else begin
        miso = sl_arr[s_idx][7 - s_falls];
      end
    end
  end

  // ---------------- bus monitors ----------------
  typedef struct { int idx; logic [7:0] b; } rx_t;
  rx_t rx_q [$];
  bit  mosi_q [$];
  int  rise_cnt    = 0;
  int  cs_rise_cnt = 0;
  int  cs_low_cyc  = 0;

  always @(posedge sclk) begin
    mosi_q.push_back(mosi);
    rise_cnt++;
  end
  always @(posedge cs_n) cs_rise_cnt++;
  always @(negedge clk) begin
    if (cs_n === 1'b0) cs_low_cyc++;
    if (rx_dv === 1'b1) rx_q.push_back('{int'(rx_count), rx_byte});
  end

  // ---------------- reference helpers ----------------
  function automatic logic [7:0] exp_rx(input logic [7:0] tx, input logic [7:0] sl);
`ifdef SPI_MASTER_LOOPBACK_EN
    return tx;
`else
    return sl;
`endif
  endfunction

  function automatic int model_nbytes(input int cnt);
    if (cnt == 0) return 1;
    if (cnt > MAXB) return MAXB;
    return cnt;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic wait_ready(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 400; i++) begin
      if (tx_ready === 1'b1) begin
        ok = 1'b1;
        return;
      end
      @(negedge clk);
    end
  endtask

  task automatic send_byte(input logic [7:0] b, input logic [CW-1:0] c, input string tag);
    tx_byte  = b;
    tx_count = c;
    tx_dv    = 1'b1;
    @(negedge clk);
    tx_dv    = 1'b0;
    tx_byte  = 8'h00;
    check({tag, "_ready_low_after_accept"}, 32'(tx_ready), 32'd0);
  endtask

  task automatic run_txn(input logic [CW-1:0] cnt, input logic [7:0] tx0, input logic [7:0] tx1,
                         input logic [7:0] sl0, input logic [7:0] sl1, input int nexp,
                         input logic [7:0] e0, input logic [7:0] e1, input int inject,
                         input string tag);
    int rx_base, mosi_base, rise_base, csr_base, low_base;
    bit ok;
    logic [7:0] got, expb;
    sl_arr[0] = sl0;
    sl_arr[1] = sl1;
    rx_base   = rx_q.size();
    mosi_base = mosi_q.size();
    rise_base = rise_cnt;
    csr_base  = cs_rise_cnt;
    low_base  = cs_low_cyc;
    for (int k = 0; k < nexp; k++) begin
      wait_ready(ok);
      check({tag, "_ready_timeout"}, 32'(ok), 32'd1);
      if (!ok) return;
      send_byte((k == 0) ? tx0 : tx1, cnt, tag);
      if (inject > 0 && k == 0) begin
        repeat (inject) @(negedge clk);
        check({tag, "_ready_in_shift"}, 32'(tx_ready), 32'd0);
        tx_byte  = 8'hFF;
        tx_count = CW'(2);
        tx_dv    = 1'b1;
        @(negedge clk);
        tx_dv    = 1'b0;
        tx_byte  = 8'h00;
      end
    end
    ok = 1'b0;
    for (int i = 0; i < 400; i++) begin
      if (cs_n === 1'b1) begin
        ok = 1'b1;
        break;
      end
      @(negedge clk);
    end
    check({tag, "_cs_release_timeout"}, 32'(ok), 32'd1);
    if (!ok) return;
    check({tag, "_gap_ready_low"}, 32'(tx_ready), 32'd0);
    wait_ready(ok);
    check({tag, "_idle_ready_timeout"}, 32'(ok), 32'd1);

    check({tag, "_rx_pulses"}, 32'(rx_q.size() - rx_base), 32'(nexp));
    for (int k = 0; k < nexp && (rx_base + k) < rx_q.size(); k++) begin
      expb = (k == 0) ? e0 : e1;
      check({tag, "_rx_index"}, 32'(rx_q[rx_base + k].idx), 32'(k));
      check({tag, "_rx_byte"}, 32'(rx_q[rx_base + k].b), 32'(expb));
    end
    check({tag, "_mosi_bits"}, 32'(mosi_q.size() - mosi_base), 32'(8 * nexp));
    for (int k = 0; k < nexp && (mosi_base + 8 * k + 7) < mosi_q.size(); k++) begin
      got = 8'h00;
      for (int b = 0; b < 8; b++) got = {got[6:0], mosi_q[mosi_base + 8 * k + b]};
      check({tag, "_mosi_byte"}, 32'(got), 32'((k == 0) ? tx0 : tx1));
    end
    check({tag, "_sclk_rises"}, 32'(rise_cnt - rise_base), 32'(8 * nexp));
    check({tag, "_cs_rises"}, 32'(cs_rise_cnt - csr_base), 32'd1);
    // Each byte occupies 18 half periods with CS low; one WAIT_NEXT cycle
    // separates bytes when the next request is issued as soon as ready.
    check({tag, "_cs_low_cycles"}, 32'(cs_low_cyc - low_base), 32'(18 * H * nexp + nexp - 1));
    check({tag, "_sclk_idle"}, 32'(sclk), 32'd0);
  endtask

  // ---------------- directed table ----------------
  typedef struct {
    logic [CW-1:0] cnt;
    logic [7:0]    tx0, tx1, sl0, sl1;
    int            nexp;
    logic [7:0]    exp0, exp1;
  } vec_t;
  vec_t vecs [6];

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1);
  end

  initial begin
    bit ok;
    int c, n;
    logic [7:0] t0, t1, s0, s1;
    int rx_base, rise_base;

    vecs[0] = '{CW'(1), 8'hA5, 8'h00, 8'h3C, 8'h00, 1, exp_rx(8'hA5, 8'h3C), 8'h00};
    vecs[1] = '{CW'(2), 8'h12, 8'h34, 8'hAB, 8'hCD, 2, exp_rx(8'h12, 8'hAB), exp_rx(8'h34, 8'hCD)};
    vecs[2] = '{CW'(0), 8'h81, 8'h00, 8'h7E, 8'h00, 1, exp_rx(8'h81, 8'h7E), 8'h00};
    vecs[3] = '{CW'(3), 8'hF0, 8'h0F, 8'h55, 8'hAA, 2, exp_rx(8'hF0, 8'h55), exp_rx(8'h0F, 8'hAA)};
    vecs[4] = '{CW'(1), 8'hC3, 8'h00, 8'h00, 8'h00, 1, exp_rx(8'hC3, 8'h00), 8'h00};
    vecs[5] = '{CW'(1), 8'hFF, 8'h00, 8'h01, 8'h00, 1, exp_rx(8'hFF, 8'h01), 8'h00};
    sl_arr[0] = 8'h00;
    sl_arr[1] = 8'h00;

    // Reset state
    repeat (3) @(negedge clk);
    check("reset_cs_n", 32'(cs_n), 32'd1);
    check("reset_sclk", 32'(sclk), 32'd0);
    check("reset_mosi", 32'(mosi), 32'd0);
    check("reset_ready", 32'(tx_ready), 32'd0);
    check("reset_rx_dv", 32'(rx_dv), 32'd0);
    check("reset_rx_count", 32'(rx_count), 32'd0);
    check("reset_rx_byte", 32'(rx_byte), 32'd0);
    rst_l = 1'b1;
    @(negedge clk);
    check("ready_after_reset", 32'(tx_ready), 32'd1);

    for (int i = 0; i < 6; i++) begin
      run_txn(vecs[i].cnt, vecs[i].tx0, vecs[i].tx1, vecs[i].sl0, vecs[i].sl1,
              vecs[i].nexp, vecs[i].exp0, vecs[i].exp1, 0, $sformatf("vec%0d", i));
    end

    // Request strobed during SHIFT must be ignored
    run_txn(CW'(1), 8'hA5, 8'h00, 8'h3C, 8'h00, 1, exp_rx(8'hA5, 8'h3C), 8'h00, 10, "ignore_dv");

    // Reset after the 4th rising edge
    sl_arr[0] = 8'h96;
    rx_base   = rx_q.size();
    rise_base = rise_cnt;
    wait_ready(ok);
    check("rst_mid_ready_timeout", 32'(ok), 32'd1);
    send_byte(8'h3E, CW'(1), "rst_mid");
    ok = 1'b0;
    for (int i = 0; i < 200; i++) begin
      if (rise_cnt - rise_base >= 4) begin
        ok = 1'b1;
        break;
      end
      @(negedge clk);
    end
    check("rst_mid_rise4_timeout", 32'(ok), 32'd1);
    #2 rst_l = 1'b0;
    #1;
    check("rst_mid_cs_n", 32'(cs_n), 32'd1);
    check("rst_mid_sclk", 32'(sclk), 32'd0);
    check("rst_mid_mosi", 32'(mosi), 32'd0);
    check("rst_mid_ready", 32'(tx_ready), 32'd0);
    check("rst_mid_rx_byte", 32'(rx_byte), 32'd0);
    check("rst_mid_rx_count", 32'(rx_count), 32'd0);
    repeat (2) @(negedge clk);
    rst_l = 1'b1;
    @(negedge clk);
    check("rst_mid_ready_after", 32'(tx_ready), 32'd1);
    repeat (40) @(negedge clk);
    check("rst_mid_no_rx_dv", 32'(rx_q.size() - rx_base), 32'd0);
    check("rst_mid_cs_idle", 32'(cs_n), 32'd1);
    run_txn(CW'(1), 8'h5A, 8'h00, 8'hC7, 8'h00, 1, exp_rx(8'h5A, 8'hC7), 8'h00, 0, "after_rst");

    // Random transactions against the byte-level model
    for (int r = 0; r < 24; r++) begin
      c  = int'($urandom_range(0, 3));
      t0 = 8'($urandom);
      t1 = 8'($urandom);
      s0 = 8'($urandom);
      s1 = 8'($urandom);
      n  = model_nbytes(c);
      run_txn(CW'(c), t0, t1, s0, s1, n, exp_rx(t0, s0), exp_rx(t1, s1), 0,
              $sformatf("rand%0d", r));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
